// File: rtl/nios_spi_xfer_ctrl.sv
// nios_spi_xfer_ctrl
// Avalon-MM slave that sequences one SPI frame transfer at a time between the
// Nios II and the DSP link. Software loads TXDATA and writes START. The block
// then pulses the SPI master and waits for the synchronised end_spi edge. It
// captures the RX frame and reports DONE/TIMEOUT through sticky status flags
// and a level interrupt.
//
// Ports
//   clk, reset_n          : system clock, async active-low reset
//   address/chipselect/
//   write_n/writedata     : Avalon-MM slave write side
//   readdata              : registered read data, 1-cycle latency
//   irq                   : registered level interrupt
//   spi_start/spi_txdata  : start pulse and TX frame to the SPI master
//   spi_rxdata/end_spi    : RX frame and async end-of-transfer strobe
//
// Register map: 0 CTRL, 1 TXDATA, 2 RXDATA, 3 CLEAR.
//
// Build option: define NIOS_SPI_XFER_TIMEOUT_EN to build the WAIT timeout
// counter and the TIMEOUT flag. Without it, WAIT only exits on an end_spi
// edge or on ABORT.
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | not busy, accepts START and TXDATA writes
// START   | spi_start pulse cycle
// WAIT    | waiting for end_spi edge (or timeout / abort)
// CAPTURE | latch spi_rxdata, set DONE
// GAP     | enforced idle gap before BUSY clears

module nios_spi_xfer_ctrl #(
   parameter int FRAME_W     = 16,
   parameter int TIMEOUT_CYC = 50000,
   parameter int GAP_CYC     = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [1:0]         address,
   input  logic               chipselect,
   input  logic               write_n,
   input  logic [31:0]        writedata,
   output logic [31:0]        readdata,
   output logic               irq,
   output logic               spi_start,
   output logic [FRAME_W-1:0] spi_txdata,
   input  logic [FRAME_W-1:0] spi_rxdata,
   input  logic               end_spi
);

   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_WAIT, ST_CAPTURE, ST_GAP
   } state_t;

   state_t             state_q, state_d;
   logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
   logic               done_q, done_d;
   logic               irq_en_q, irq_en_d;
   logic [FRAME_W-1:0] txdata_q, txdata_d;
   logic [FRAME_W-1:0] rxdata_q, rxdata_d;
   logic [31:0]        readdata_q, readdata_d;
   logic               irq_q, irq_d;
   logic               spi_start_q, spi_start_d;
   logic [2:0]         sync_q, sync_d;

   logic wr_en, ctrl_wr, start_cmd, abort_cmd, clr_wr, end_edge, busy, tmo_flag;
   logic [31:0] unused_wdata;

   assign unused_wdata = writedata;
   assign wr_en     = chipselect & ~write_n;
   assign ctrl_wr   = wr_en & (address == 2'd0);
   assign clr_wr    = wr_en & (address == 2'd3);
   // ABORT takes precedence over START within the same write
   assign abort_cmd = ctrl_wr & writedata[2];
   assign start_cmd = ctrl_wr & writedata[0] & ~writedata[2];
   // sync_q[0..1] is the 2-FF synchroniser, sync_q[2] the edge register
   assign sync_d    = {sync_q[1:0], end_spi};
   assign end_edge  = sync_q[1] & ~sync_q[2];
   assign busy      = (state_q != ST_IDLE);

`ifdef NIOS_SPI_XFER_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          tmo_q, tmo_d;
   assign tmo_flag = tmo_q;
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = (TIMEOUT_CYC > 0);
   assign tmo_flag = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      gap_cnt_d   = '0;
      done_d      = done_q;
      irq_en_d    = irq_en_q;
      txdata_d    = txdata_q;
      rxdata_d    = rxdata_q;
      spi_start_d = 1'b0;
`ifdef NIOS_SPI_XFER_TIMEOUT_EN
      tmo_d       = tmo_q;
      tmo_cnt_d   = '0;
      if (clr_wr && writedata[2]) tmo_d = 1'b0;
`endif
      if (ctrl_wr) irq_en_d = writedata[1];
      if (wr_en && (address == 2'd1) && !busy) txdata_d = writedata[FRAME_W-1:0];
      // clears first so that a same-cycle set below wins
      if (clr_wr && writedata[1]) done_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_cmd) begin
               state_d     = ST_START;
               spi_start_d = 1'b1;
            end
         end
         ST_START: begin
            if (abort_cmd) state_d = ST_GAP;
            else           state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (abort_cmd)     state_d = ST_GAP;
            else if (end_edge) state_d = ST_CAPTURE;
`ifdef NIOS_SPI_XFER_TIMEOUT_EN
            else if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
               state_d = ST_GAP;
               tmo_d   = 1'b1;
            end
            else tmo_cnt_d = tmo_cnt_q + TW'(1);
`endif
         end
         ST_CAPTURE: begin
            rxdata_d = spi_rxdata;
            done_d   = 1'b1;
            state_d  = ST_GAP;
         end
         ST_GAP: begin
            if (gap_cnt_q == GW'(GAP_CYC - 1)) state_d = ST_IDLE;
            else                               gap_cnt_d = gap_cnt_q + GW'(1);
         end
         default: state_d = ST_IDLE;
      endcase

      case (address)
         2'd0:    readdata_d = {28'd0, irq_en_q, tmo_flag, done_q, busy};
         2'd1:    readdata_d = 32'(txdata_q);
         2'd2:    readdata_d = 32'(rxdata_q);
         default: readdata_d = 32'd0;
      endcase

      irq_d = irq_en_q & (done_q | tmo_flag);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         gap_cnt_q   <= '0;
         done_q      <= 1'b0;
         irq_en_q    <= 1'b0;
         txdata_q    <= '0;
         rxdata_q    <= '0;
         readdata_q  <= '0;
         irq_q       <= 1'b0;
         spi_start_q <= 1'b0;
         sync_q      <= '0;
`ifdef NIOS_SPI_XFER_TIMEOUT_EN
         tmo_q       <= 1'b0;
         tmo_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         gap_cnt_q   <= gap_cnt_d;
         done_q      <= done_d;
         irq_en_q    <= irq_en_d;
         txdata_q    <= txdata_d;
         rxdata_q    <= rxdata_d;
         readdata_q  <= readdata_d;
         irq_q       <= irq_d;
         spi_start_q <= spi_start_d;
         sync_q      <= sync_d;
`ifdef NIOS_SPI_XFER_TIMEOUT_EN
         tmo_q       <= tmo_d;
         tmo_cnt_q   <= tmo_cnt_d;
`endif
      end
   end

   assign readdata   = readdata_q;
   assign irq        = irq_q;
   assign spi_start  = spi_start_q;
   assign spi_txdata = txdata_q;

endmodule

// File: tb/tb_nios_spi_xfer_ctrl.sv
module tb_nios_spi_xfer_ctrl;

   localparam int FW  = 16;
   localparam int TO  = 20;
   localparam int GAP = 4;
`ifdef NIOS_SPI_XFER_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [1:0]    address = '0;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic [31:0]   writedata = '0;
   logic [31:0]   readdata;
   logic          irq;
   logic          spi_start;
   logic [FW-1:0] spi_txdata;
   logic [FW-1:0] spi_rxdata = '0;
   logic          end_spi = 1'b0;

   nios_spi_xfer_ctrl #(.FRAME_W(FW), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
      .spi_start(spi_start), .spi_txdata(spi_txdata), .spi_rxdata(spi_rxdata),
      .end_spi(end_spi)
   );

   always #5 clk = ~clk;

   int ecount = 0;
   always @(posedge clk) ecount++;

   // Behavioural model: every register/flag is a value that switches at a
   // known clock edge; the value seen "after edge x" is tv_get(v, x).
   typedef struct { logic [31:0] prev; logic [31:0] cur; int e; } tv_t;
   typedef struct { int e; logic [31:0] exp; logic [1:0] a; } rd_t;
   typedef struct { int e; logic [31:0] tx; } st_t;

   tv_t m_busy, m_done, m_tmo, m_irqen, m_tx, m_rx;
   rd_t rd_q[$];
   st_t st_q[$];
   int  nchk = 0, nerr = 0, end_cnt = 0;

   function automatic logic [31:0] tv_get(input tv_t v, input int x);
      return (x >= v.e) ? v.cur : v.prev;
   endfunction

   function automatic tv_t tv_set(input tv_t v, input logic [31:0] val, input int e);
      tv_t r;
      r.prev = tv_get(v, e - 1);
      r.cur  = val;
      r.e    = e;
      return r;
   endfunction

   // a set landing on the same edge as a clear wins
   function automatic tv_t tv_clr(input tv_t v, input int e);
      if (v.e == e && v.cur == 32'd1) return v;
      return tv_set(v, 32'd0, e);
   endfunction

   function automatic void model_reset();
      tv_t z;
      z.prev = '0; z.cur = '0; z.e = 0;
      m_busy = z; m_done = z; m_tmo = z; m_irqen = z; m_tx = z; m_rx = z;
   endfunction

   function automatic logic [31:0] rd_exp(input logic [1:0] a, input int x);
      logic b, d, t, ie;
      b  = tv_get(m_busy, x)  != 0;
      d  = tv_get(m_done, x)  != 0;
      t  = tv_get(m_tmo, x)   != 0;
      ie = tv_get(m_irqen, x) != 0;
      case (a)
         2'd0:    return {28'd0, ie, t, d, b};
         2'd1:    return tv_get(m_tx, x);
         2'd2:    return tv_get(m_rx, x);
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic irq_exp(input int x);
      return (tv_get(m_irqen, x) != 0) &&
             ((tv_get(m_done, x) != 0) || (tv_get(m_tmo, x) != 0));
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", nm, act, exp, ecount);
      end
   endtask

   // monitor: pops scoreboard entries when the DUT presents them
   always @(negedge clk) begin
      rd_t r;
      st_t s;
      if (reset_n) begin
         while (rd_q.size() > 0 && rd_q[0].e < ecount) begin
            r = rd_q.pop_front();
            chk("readdata_missed", 32'(ecount), 32'(r.e));
         end
         if (rd_q.size() > 0 && rd_q[0].e == ecount) begin
            r = rd_q.pop_front();
            chk($sformatf("readdata_addr%0d", r.a), readdata, r.exp);
         end
         chk("irq", 32'(irq), 32'(irq_exp(ecount - 1)));
         if (spi_start) begin
            if (st_q.size() == 0) chk("spi_start_unexpected", 32'd1, 32'd0);
            else begin
               s = st_q.pop_front();
               chk("spi_start_edge", 32'(ecount), 32'(s.e));
               chk("spi_txdata", 32'(spi_txdata), s.tx);
            end
         end
      end
   end

   // one bus cycle: drive, predict readdata for the next edge, apply write effects
   task automatic cycle(input logic [1:0] a, input logic wr, input logic [31:0] wd);
      int x, e;
      rd_t r;
      x = ecount;
      e = ecount + 1;
      address   = a;
      writedata = wd;
      if (wr) begin
         chipselect = 1'b1;
         write_n    = 1'b0;
      end else begin
         chipselect = 1'($urandom_range(0, 1));
         write_n    = chipselect ? 1'b1 : 1'($urandom_range(0, 1));
      end
      r.e = e; r.exp = rd_exp(a, x); r.a = a;
      rd_q.push_back(r);
      if (wr) begin
         case (a)
            2'd0: m_irqen = tv_set(m_irqen, {31'd0, wd[1]}, e);
            2'd1: if (tv_get(m_busy, x) == 0) m_tx = tv_set(m_tx, wd & 32'hFFFF, e);
            2'd3: begin
               if (wd[1]) m_done = tv_clr(m_done, e);
               if (wd[2] && TMO_EN) m_tmo = tv_clr(m_tmo, e);
            end
            default: ;
         endcase
      end
      @(posedge clk);
      #1;
      if (end_cnt > 0) begin
         end_cnt--;
         if (end_cnt == 0) end_spi = 1'b0;
      end
   endtask

   task automatic rnd_read();
      cycle(2'($urandom_range(0, 3)), 1'b0, $urandom);
   endtask

   task automatic start_xfer(input logic [15:0] tx, input bit ie);
      int T;
      st_t s;
      cycle(2'd3, 1'b1, 32'h6);
      cycle(2'd1, 1'b1, 32'(tx));
      T = ecount + 1;
      s.e = T; s.tx = tv_get(m_tx, T);
      st_q.push_back(s);
      cycle(2'd0, 1'b1, {29'd0, 1'b0, ie, 1'b1});
      m_busy = tv_set(m_busy, 32'd1, T);
   endtask

   // mode 0: normal, 1: timeout, 2: abort
   task automatic xfer(input int mode_i, input logic [15:0] tx, input logic [15:0] rx,
                       input bit ie, input bit prot, input int dly, input int w,
                       input bit setwin, input bit stray);
      int T, P, A, stop, mode;
      mode = (mode_i == 1 && !TMO_EN) ? 2 : mode_i;
      start_xfer(tx, ie);
      T = ecount;
      stop = 0;
      if (mode == 1) begin
         m_tmo  = tv_set(m_tmo, 32'd1, T + 1 + TO);
         m_busy = tv_set(m_busy, 32'd0, T + 1 + TO + GAP);
         stop   = T + 1 + TO + GAP;
      end
      for (int i = 0; i < dly; i++) begin
         if (prot && i == 0)      cycle(2'd1, 1'b1, 32'hFFFF);
         else if (prot && i == 1) cycle(2'd0, 1'b1, {29'd0, 1'b0, ie, 1'b1});
         else                     rnd_read();
      end
      if (mode == 0) begin
         P = ecount;
         spi_rxdata = rx;
         end_spi    = 1'b1;
         end_cnt    = w;
         m_done = tv_set(m_done, 32'd1, P + 4);
         m_rx   = tv_set(m_rx, 32'(rx), P + 4);
         m_busy = tv_set(m_busy, 32'd0, P + 4 + GAP);
         stop   = P + 4 + GAP;
         while (ecount < stop + 2) begin
            if (setwin && ecount + 1 == P + 4) cycle(2'd3, 1'b1, 32'h2);
            else rnd_read();
         end
      end else if (mode == 2) begin
         A = ecount + 1;
         cycle(2'd0, 1'b1, {29'd0, 1'b1, ie, 1'($urandom_range(0, 1))});
         m_busy = tv_set(m_busy, 32'd0, A + GAP);
         stop   = A + GAP;
         if (stray) begin
            spi_rxdata = rx;
            end_spi    = 1'b1;
            end_cnt    = 3;
         end
         while (ecount < stop + 2) rnd_read();
      end else begin
         while (ecount < stop + 2) rnd_read();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, edge %0d", ecount);
      $fatal(1);
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_readdata", readdata, 32'd0);
      chk("reset_irq", 32'(irq), 32'd0);
      chk("reset_spi_start", 32'(spi_start), 32'd0);
      chk("reset_spi_txdata", 32'(spi_txdata), 32'd0);
      reset_n = 1'b1;
      repeat (3) cycle(2'd0, 1'b0, 32'd0);

      // normal transfer with interrupt, then clear DONE
      xfer(0, 16'hA5C3, 16'h1234, 1'b1, 1'b0, 2, 4, 1'b0, 1'b0);
      cycle(2'd3, 1'b1, 32'h2);
      cycle(2'd0, 1'b0, 32'd0);
      cycle(2'd2, 1'b0, 32'd0);
      // timeout (becomes an abort when the timeout logic is not built)
      xfer(1, 16'h5A5A, 16'hBEEF, 1'b1, 1'b0, 3, 4, 1'b0, 1'b0);
      // busy protection
      xfer(0, 16'h0F0F, 16'hC001, 1'b0, 1'b1, 4, 3, 1'b0, 1'b0);
      cycle(2'd1, 1'b0, 32'd0);
      // abort in WAIT with stray end_spi in GAP, then stray pulse in IDLE
      xfer(2, 16'h1111, 16'h2222, 1'b1, 1'b0, 3, 4, 1'b0, 1'b1);
      end_spi = 1'b1;
      end_cnt = 4;
      repeat (10) rnd_read();
      // abort while still in START
      xfer(2, 16'h3333, 16'h4444, 1'b0, 1'b0, 0, 4, 1'b0, 1'b0);
      // set and clear of DONE on the same edge
      xfer(0, 16'h7777, 16'h8888, 1'b1, 1'b0, 1, 5, 1'b1, 1'b0);

      for (int n = 0; n < 12; n++) begin
         int md;
         bit pr;
         md = $urandom_range(0, 2);
         pr = 1'($urandom_range(0, 1));
         xfer(md, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), pr,
              pr ? $urandom_range(2, 8) : $urandom_range(0, 8),
              $urandom_range(3, 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // reset in the middle of WAIT; a late end_spi must be ignored
      start_xfer(16'hDEAD, 1'b1);
      repeat (3) rnd_read();
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      rd_q.delete();
      #1;
      chk("midreset_readdata", readdata, 32'd0);
      chk("midreset_irq", 32'(irq), 32'd0);
      chk("midreset_spi_start", 32'(spi_start), 32'd0);
      chk("midreset_spi_txdata", 32'(spi_txdata), 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_n    = 1'b1;
      spi_rxdata = 16'h5555;
      end_spi    = 1'b1;
      end_cnt    = 4;
      repeat (10) cycle(2'($urandom_range(0, 2)), 1'b0, 32'd0);
      cycle(2'd0, 1'b0, 32'd0);
      cycle(2'd0, 1'b0, 32'd0);
      @(negedge clk);
      #1;
      chk("scoreboard_reads_drained", 32'(rd_q.size()), 32'd0);
      chk("scoreboard_starts_drained", 32'(st_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
